fft_output_reorder: RTL

- Sits directly downstream of the 16-point radix-2^2 SDF FFT datapath and its control unit.
- Consumes the FFT's bit-reversed output stream, qualified by FFT_Valid.
- Emits the 16 bins in natural order (k = 0..15) with a bin index and frame-boundary flags.
- Uses a 2-bank ping-pong buffer so continuous frames stream out without gaps.

---
 rtl/fft_output_reorder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fft_output_reorder.sv
// Reorders the bit-reversed 16-point FFT output into natural bin order through a 2-bank ping-pong buffer.
// Optional build macro OUT_SCALE_EN: applies 1/N normalisation with round-half-up on the emitted bins.
module fft_output_reorder #(
  parameter int WIDTH    = 16,
  parameter int N_POINTS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FFT_Valid,
  input  logic [WIDTH-1:0] FFT_Real,
  input  logic [WIDTH-1:0] FFT_Imag,
  output logic [WIDTH-1:0] Out_Real,
  output logic [WIDTH-1:0] Out_Imag,
  output logic             Out_Valid,
  output logic [3:0]       Out_Index,
  output logic             Out_Frame_Start,
  output logic             Out_Frame_End
);

  localparam int AW = $clog2(N_POINTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_t;

  logic [WIDTH-1:0] mem_re [2][N_POINTS];
  logic [WIDTH-1:0] mem_im [2][N_POINTS];

  logic [AW-1:0]    wr_cnt_r;
  logic             wr_bank_r;
  logic [1:0]       full_r;
  logic [AW-1:0]    rd_cnt_r;
  logic             rd_bank_r;
  rd_state_t        state_r;

  logic [WIDTH-1:0] out_real_r;
  logic [WIDTH-1:0] out_imag_r;
  logic             out_valid_r;
  logic [3:0]       out_index_r;
  logic             out_start_r;
  logic             out_end_r;

  logic             wr_last_s;
  logic             rd_last_s;
  logic             other_full_s;
  logic [1:0]       full_set_s;
  logic [1:0]       full_clr_s;
  logic [AW-1:0]    rd_addr_s;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] out_scale(input logic [WIDTH-1:0] x);
`ifdef OUT_SCALE_EN
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] sh;
    ext = {x[WIDTH-1], x} + {{(WIDTH-3){1'b0}}, 4'd8};
    sh  = ext >>> 3'd4;
    return sh[WIDTH-1:0];
`else
    return x;
`endif
  endfunction

  assign wr_last_s  = FFT_Valid && (wr_cnt_r == {AW{1'b1}});
  assign rd_last_s  = (state_r == ST_READ) && (rd_cnt_r == {AW{1'b1}});
  assign full_set_s = wr_last_s ? (2'b01 << wr_bank_r) : 2'b00;
  assign full_clr_s = rd_last_s ? (2'b01 << rd_bank_r) : 2'b00;
  assign rd_addr_s  = bitrev(rd_cnt_r);
  // A bank completed by the writer on this very edge counts as ready, giving gapless hand-over
  assign other_full_s = full_r[~rd_bank_r] | (wr_last_s && (wr_bank_r != rd_bank_r));

  // Sample storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (FFT_Valid) begin
      mem_re[wr_bank_r][wr_cnt_r] <= FFT_Real;
      mem_im[wr_bank_r][wr_cnt_r] <= FFT_Imag;
    end
  end

  // Write counter and write bank pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_r  <= {AW{1'b0}};
      wr_bank_r <= 1'b0;
    end else if (FFT_Valid) begin
      wr_cnt_r <= wr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
      if (wr_last_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Bank-full flags: writer sets, reader clears, never on the same bank in one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r | full_set_s) & ~full_clr_s;
    end
  end

  // Read FSM with registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rd_cnt_r    <= {AW{1'b0}};
      rd_bank_r   <= 1'b0;
      out_real_r  <= {WIDTH{1'b0}};
      out_imag_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_index_r <= 4'd0;
      out_start_r <= 1'b0;
      out_end_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          out_start_r <= 1'b0;
          out_end_r   <= 1'b0;
          rd_cnt_r    <= {AW{1'b0}};
          if (full_r[rd_bank_r]) begin
            state_r <= ST_READ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          out_real_r  <= out_scale(mem_re[rd_bank_r][rd_addr_s]);
          out_imag_r  <= out_scale(mem_im[rd_bank_r][rd_addr_s]);
          out_valid_r <= 1'b1;
          out_index_r <= rd_cnt_r;
          out_start_r <= (rd_cnt_r == {AW{1'b0}});
          out_end_r   <= (rd_cnt_r == {AW{1'b1}});
          rd_cnt_r    <= rd_cnt_r + {{(AW-1){1'b0}}, 1'b1};
          if (rd_last_s) begin
            rd_bank_r <= ~rd_bank_r;
            state_r   <= other_full_s ? ST_READ : ST_IDLE;
          end else begin
            state_r <= ST_READ;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rd_cnt_r    <= {AW{1'b0}};
          out_valid_r <= 1'b0;
          out_start_r <= 1'b0;
          out_end_r   <= 1'b0;
        end
      endcase
    end
  end

  assign Out_Real        = out_real_r;
  assign Out_Imag        = out_imag_r;
  assign Out_Valid       = out_valid_r;
  assign Out_Index       = out_index_r;
  assign Out_Frame_Start = out_start_r;
  assign Out_Frame_End   = out_end_r;

endmodule
